// File: rtl/sim_uart_rx_pkg.sv
// Shared types and constants for the simulation-side UART receive monitor.
package sim_uart_rx_pkg;

    typedef enum logic [2:0] {
        Idle,
        Start,
        Data,
        Stop,
        WaitHigh
    } rx_state_e;

    localparam logic [7:0] LineFeed = 8'h0A;
    localparam int         RxCountW = 16;

endpackage

// File: rtl/sim_uart_rx_fifo.sv
// Synchronous receive FIFO; a push into a full FIFO is still accepted when a pop happens in the same cycle.
module sim_uart_rx_fifo #(
    parameter int FifoDepth = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [7:0]                   data_i,
    input  logic                         pop_i,
    output logic                         push_ok_o,
    output logic [7:0]                   data_o,
    output logic                         valid_o,
    output logic [$clog2(FifoDepth):0]   depth_o
);

    localparam int             PtrW = $clog2(FifoDepth);
    localparam logic [PtrW:0]  Full = (PtrW + 1)'(FifoDepth);

    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW:0]   count;
    logic            pop_fire;
    logic            push_fire;

    assign pop_fire  = pop_i && (count != '0);
    assign push_fire = push_i && ((count != Full) || pop_fire);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_fire) mem[wr_ptr] <= data_i;
    end

    assign valid_o   = (count != '0);
    assign data_o    = valid_o ? mem[rd_ptr] : 8'h00;
    assign depth_o   = count;
    assign push_ok_o = push_fire;

endmodule

// File: rtl/sim_uart_rx_monitor.sv
// 8N1 UART receiver for the chip-level bench: synchronizer, bit-timing FSM, byte FIFO and status pulses.
module sim_uart_rx_monitor
    import sim_uart_rx_pkg::*;
#(
    parameter int ClksPerBit = 69,
    parameter int FifoDepth  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rx_i,
    output logic [7:0]                  data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic                        line_done_o,
    output logic                        frame_err_o,
    output logic                        overflow_o,
    output logic [RxCountW-1:0]         rx_count_o,
    output logic [$clog2(FifoDepth):0]  fifo_depth_o
);

    localparam int              CntW       = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] BitReload  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfReload = CntW'((ClksPerBit >> 1) - 1);

    rx_state_e       state, state_next;
    logic [CntW-1:0] cnt, cnt_next;
    logic [2:0]      bit_idx, idx_next;
    logic [7:0]      shift_q, shift_next;
    logic            rx_meta, rx_s;
    logic            push, frame_err, push_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= Idle;
            cnt     <= '0;
            bit_idx <= '0;
            shift_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= idx_next;
            shift_q <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = bit_idx;
        shift_next = shift_q;
        push       = 1'b0;
        frame_err  = 1'b0;
        case (state)
            Idle: begin
                if (!rx_s) begin
                    state_next = Start;
                    cnt_next   = HalfReload;
                end
            end
            Start: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (!rx_s) begin
                    state_next = Data;
                    cnt_next   = BitReload;
                    idx_next   = '0;
                end else begin
                    state_next = Idle;
                end
            end
            Data: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    shift_next = {rx_s, shift_q[7:1]};
                    cnt_next   = BitReload;
                    idx_next   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_next = Stop;
                end
            end
            Stop: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (rx_s) begin
                    push       = 1'b1;
                    state_next = Idle;
                end else begin
                    frame_err  = 1'b1;
                    state_next = WaitHigh;
                end
            end
            WaitHigh: begin
                if (rx_s) state_next = Idle;
            end
            default: state_next = Idle;
        endcase
    end

    sim_uart_rx_fifo #(
        .FifoDepth (FifoDepth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .data_i    (shift_q),
        .pop_i     (ready_i),
        .push_ok_o (push_ok),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .depth_o   (fifo_depth_o)
    );

    // Pulses are registered so they line up with the pushed byte appearing at the FIFO head.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_done_o <= 1'b0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
            rx_count_o  <= '0;
        end else begin
            line_done_o <= push_ok && (shift_q == LineFeed);
            frame_err_o <= frame_err;
            overflow_o  <= push && !push_ok;
            if (push_ok && (rx_count_o != '1)) rx_count_o <= rx_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_sim_uart_rx_monitor.sv
// Directed bench for sim_uart_rx_monitor with ClksPerBit = 8 and FifoDepth = 4.
module tb_sim_uart_rx_monitor;

    localparam int Cpb   = 8;
    localparam int Depth = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        rx_i = 1'b1;
    logic        ready_i = 1'b0;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        line_done_o;
    logic        frame_err_o;
    logic        overflow_o;
    logic [15:0] rx_count_o;
    logic [2:0]  fifo_depth_o;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          fall_cyc = 0;
    logic [7:0]  got[$];
    int          ld_cnt, ferr_cnt, ovf_cnt, valid_cycles, rise_cyc;
    logic [7:0]  ld_data;
    logic        prev_valid;

    sim_uart_rx_monitor #(
        .ClksPerBit (Cpb),
        .FifoDepth  (Depth)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .line_done_o  (line_done_o),
        .frame_err_o  (frame_err_o),
        .overflow_o   (overflow_o),
        .rx_count_o   (rx_count_o),
        .fifo_depth_o (fifo_depth_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer-side monitor: records popped bytes and counts status pulses between resets.
    always @(negedge clk) begin
        if (rst_i) begin
            got.delete();
            ld_cnt       <= 0;
            ferr_cnt     <= 0;
            ovf_cnt      <= 0;
            valid_cycles <= 0;
            rise_cyc     <= 0;
            ld_data      <= 8'h00;
            prev_valid   <= 1'b0;
        end else begin
            if (valid_o && ready_i) got.push_back(data_o);
            if (valid_o) valid_cycles <= valid_cycles + 1;
            if (valid_o && !prev_valid) rise_cyc <= cyc;
            if (line_done_o) begin
                ld_cnt  <= ld_cnt + 1;
                ld_data <= data_o;
            end
            if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
            if (overflow_o) ovf_cnt <= ovf_cnt + 1;
            prev_valid <= valid_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got.size()) return 32'(got[i]);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic applyReset();
        rst_i = 1'b1;
        rx_i  = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        repeat (3) tick();
    endtask

    // One 8N1 frame; pop_at >= 0 raises ready_i for exactly that bit-time tick of the frame.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int pop_at);
        for (int k = 0; k < 10 * Cpb; k++) begin
            if (k == 0) fall_cyc = cyc;
            if (k < Cpb)          rx_i = 1'b0;
            else if (k < 9 * Cpb) rx_i = b[(k - Cpb) / Cpb];
            else                  rx_i = stop_bit;
            if (pop_at >= 0) ready_i = (k == pop_at);
            tick();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_data"},      32'(data_o),       32'h0);
        checkOutput({tag, "_valid"},     32'(valid_o),      32'h0);
        checkOutput({tag, "_line_done"}, 32'(line_done_o),  32'h0);
        checkOutput({tag, "_frame_err"}, 32'(frame_err_o),  32'h0);
        checkOutput({tag, "_overflow"},  32'(overflow_o),   32'h0);
        checkOutput({tag, "_rx_count"},  32'(rx_count_o),   32'h0);
        checkOutput({tag, "_depth"},     32'(fifo_depth_o), 32'h0);
    endtask

    initial begin
        applyReset();
        checkResetOutputs("reset");

        // Single frame, consumer always ready: head visible 2+4+72+1 cycles after the falling edge.
        ready_i = 1'b1;
        applyStimulus(8'h55, 1'b1, -1);
        repeat (4) tick();
        checkOutput("t1_latency",      32'(rise_cyc - fall_cyc), 32'd79);
        checkOutput("t1_valid_cycles", 32'(valid_cycles),        32'd1);
        checkOutput("t1_count",        32'(got.size()),          32'd1);
        checkOutput("t1_byte",         got_at(0),                32'h55);
        checkOutput("t1_rx_count",     32'(rx_count_o),          32'd1);

        // Back-to-back "A\n".
        applyReset();
        ready_i = 1'b1;
        applyStimulus(8'h41, 1'b1, -1);
        applyStimulus(8'h0A, 1'b1, -1);
        repeat (4) tick();
        checkOutput("t2_count",     32'(got.size()),  32'd2);
        checkOutput("t2_byte0",     got_at(0),        32'h41);
        checkOutput("t2_byte1",     got_at(1),        32'h0A);
        checkOutput("t2_ld_pulses", 32'(ld_cnt),      32'd1);
        checkOutput("t2_ld_data",   32'(ld_data),     32'h0A);
        checkOutput("t2_rx_count",  32'(rx_count_o),  32'd2);

        // Three-cycle glitch, then a real frame to show the receiver is back in Idle.
        applyReset();
        ready_i = 1'b1;
        rx_i = 1'b0;
        repeat (3) tick();
        rx_i = 1'b1;
        repeat (20) tick();
        checkOutput("t3_rx_count",  32'(rx_count_o), 32'd0);
        checkOutput("t3_no_push",   32'(got.size()), 32'd0);
        checkOutput("t3_no_ferr",   32'(ferr_cnt),   32'd0);
        applyStimulus(8'h5A, 1'b1, -1);
        repeat (4) tick();
        checkOutput("t3_after_cnt",  32'(got.size()), 32'd1);
        checkOutput("t3_after_byte", got_at(0),       32'h5A);

        // Framing error followed by a stuck-low line, then a good frame.
        applyReset();
        ready_i = 1'b1;
        applyStimulus(8'hA5, 1'b0, -1);
        repeat (40) tick();
        rx_i = 1'b1;
        repeat (10) tick();
        applyStimulus(8'h3C, 1'b1, -1);
        repeat (4) tick();
        checkOutput("t4_ferr_pulses", 32'(ferr_cnt),   32'd1);
        checkOutput("t4_count",       32'(got.size()), 32'd1);
        checkOutput("t4_byte",        got_at(0),       32'h3C);
        checkOutput("t4_rx_count",    32'(rx_count_o), 32'd1);

        // Overflow: six frames into a four-entry FIFO with no consumer.
        applyReset();
        ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) applyStimulus(8'(i), 1'b1, -1);
        repeat (4) tick();
        checkOutput("t5_depth",     32'(fifo_depth_o), 32'd4);
        checkOutput("t5_ovf",       32'(ovf_cnt),      32'd2);
        checkOutput("t5_rx_count",  32'(rx_count_o),   32'd4);
        checkOutput("t5_valid",     32'(valid_o),      32'd1);
        checkOutput("t5_head",      32'(data_o),       32'h01);
        ready_i = 1'b1;
        repeat (6) tick();
        ready_i = 1'b0;
        checkOutput("t5_drain_cnt", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t5_drain%0d", i), got_at(i), 32'(i + 1));

        // Full FIFO with a pop in the same cycle as the push of 0x07.
        applyReset();
        ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1, -1);
        repeat (2) tick();
        checkOutput("t6_full_depth", 32'(fifo_depth_o), 32'd4);
        applyStimulus(8'h07, 1'b1, 10 * Cpb - 2);
        repeat (2) tick();
        checkOutput("t6_ovf",      32'(ovf_cnt),      32'd0);
        checkOutput("t6_depth",    32'(fifo_depth_o), 32'd4);
        checkOutput("t6_rx_count", 32'(rx_count_o),   32'd5);
        ready_i = 1'b1;
        repeat (6) tick();
        ready_i = 1'b0;
        checkOutput("t6_drain_cnt", 32'(got.size()), 32'd5);
        checkOutput("t6_first",     got_at(0),       32'h01);
        checkOutput("t6_last",      got_at(4),       32'h07);

        // Reset in the middle of a frame with bytes still buffered.
        applyStimulus(8'h21, 1'b1, -1);
        applyStimulus(8'h22, 1'b1, -1);
        rx_i = 1'b0;
        repeat (20) tick();
        checkOutput("t6_pre_rst_depth", 32'(fifo_depth_o), 32'd2);
        rst_i = 1'b1;
        rx_i  = 1'b1;
        repeat (2) tick();
        checkResetOutputs("midrst");
        rst_i = 1'b0;
        repeat (5) tick();
        ready_i = 1'b1;
        applyStimulus(8'h11, 1'b1, -1);
        repeat (4) tick();
        checkOutput("t6_post_cnt",      32'(got.size()), 32'd1);
        checkOutput("t6_post_byte",     got_at(0),       32'h11);
        checkOutput("t6_post_rx_count", 32'(rx_count_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
